sobel_stream_ctrl: RTL and testbench
====================================

Name: sobel_stream_ctrl

Overview:
Parametrised successor to the fixed 3x3 Sobel controller. It accepts a raster pixel stream on a valid/ready interface and keeps two rows in line buffers. Once the buffers are primed it forms one 3x3 window per accepted pixel and emits one filtered interior pixel per window, with runtime-selectable filter mode and output backpressure. It sits between the grayscale converter stream and the output serialiser.

Parameters:
PIXEL_W, 8, pixel width in bits (input and output)
IMG_W, 160, frame width in pixels (>=3)
IMG_H, 120, frame height in pixels (>=3)
COL_BITS, $clog2(IMG_W), column counter width (derived)
ROW_BITS, $clog2(IMG_H), row counter width (derived)

Ports:
clk_i  in  1  clock; all logic on rising edge
reset_i  in  1  asynchronous, active-high reset
start_i  in  1  one-cycle frame start pulse; sampled in IDLE only
mode_i  in  2  filter mode; latched on start_i
threshold_i  in  PIXEL_W  binary threshold; latched on start_i
in_px_i  in  PIXEL_W  input pixel, raster order
in_valid_i  in  1  input pixel valid
in_ready_o  out  1  block accepts in_px_i this cycle
out_px_o  out  PIXEL_W  filtered pixel
out_valid_o  out  1  out_px_o valid
out_ready_i  in  1  downstream accepts out_px_o
busy_o  out  1  high in every state except IDLE
frame_done_o  out  1  one-cycle pulse when the last output has been accepted

Behaviour:
- Reset (any time, including mid-frame): state IDLE; counters, window, pipeline valids cleared; all outputs 0. Line buffer contents are not reset; they are refilled before use.
- Transfer rules:
  - Input transfer = in_valid_i & in_ready_o.
  - Output transfer = out_valid_o & out_ready_i.
  - out_px_o must hold stable while out_valid_o & !out_ready_i.
- Stall: stall = out_valid_o & !out_ready_i. When stall is high, the whole pipeline freezes.
- in_ready_o = (state==RUN) & !stall. No combinational path from in_valid_i to in_ready_o.
- FSM:
  - IDLE: start_i -> RUN; latch mode_i and threshold_i; clear col/row counters.
  - RUN: each input transfer increments col. col wraps at IMG_W-1 and increments row. Transfer at (IMG_H-1, IMG_W-1) -> DRAIN.
  - DRAIN: in_ready_o=0. When both pipeline stages are empty -> IDLE, with frame_done_o=1 for that one cycle.
  - start_i outside IDLE is ignored. in_valid_i outside RUN is ignored.
- Window:
  - On an input transfer, the window shifts left one column. The new right column = {linebuf row r-2, linebuf row r-1, in_px_i} at column c.
  - Line buffer column c is then updated to {old r-1 value, in_px_i}.
- Window valid (stage 1) is set when the transfer has row>=2 and col>=2; its centre is (row-1, col-1). Only interior pixels are output: (IMG_W-2)*(IMG_H-2) per frame, in raster order.
- Latency: output appears 2 cycles after the completing input transfer when not stalled (stage 1 = window register, stage 2 = output register).
- Arithmetic:
  - Gx = (p02+2p12+p22)-(p00+2p10+p20).
  - Gy = (p20+2p21+p22)-(p00+2p01+p02).
  - Both are signed, PIXEL_W+3 bits.
  - mag = |Gx|+|Gy|, PIXEL_W+4 bits unsigned.
- Modes:
  - 0: mag, saturated to 2^PIXEL_W-1.
  - 1: all-ones if mag >= threshold, else 0.
  - 2: |Gx| only, saturated.
  - 3: passthrough of centre pixel p11.

Decomposition:
- Shared package: mode enum (MODE_MAG, MODE_THRESH, MODE_GX, MODE_PASS), state enum (IDLE, RUN, DRAIN), and a packed 3x3 window struct parametrised by PIXEL_W.
- One sub-module, sobel_line_buffer: IMG_W x 2*PIXEL_W storage.
  - Indexed by column; reads are combinational.
  - Write on enable.
  - No reset on the storage array.
- Kernel arithmetic stays in this block as a function.

Test Plan:
All directed tests use IMG_W=8, IMG_H=6, which gives 24 outputs per frame.
1. Flat image, every pixel 100, mode 0, out_ready_i=1 -> 24 outputs, all 0; frame_done_o pulses once; busy_o low afterwards.
2. Vertical edge, cols 0-3=0 and cols 4-7=200, mode 0 -> every output row is 0,0,255,255,0,0. Mode 2 gives identical results.
3. Horizontal edge, rows 0-2=0 and rows 3-5=200:
   - mode 2 -> all 24 outputs are 0;
   - mode 0 -> output rows 2 and 3 are all 255, rows 1 and 4 are all 0.
4. Mode 3 with pixel value = 8*row+col, mode 1 with threshold 50 on the test-2 image:
   - mode 3 -> outputs 9,10,...,14,17,... (centre values);
   - mode 1 -> output rows 0,0,255,255,0,0.
5. Backpressure: out_ready_i low for 10 cycles mid-frame -> in_ready_o drops within the same cycle stall asserts; out_px_o stays stable; no outputs lost or duplicated; the 24 outputs match test 2 in order.
6. Reset pulse after 20 input pixels, then a fresh start_i with the test-1 image -> all outputs 0 immediately after reset; the next frame produces exactly 24 zeros and one frame_done_o. start_i pulsed during RUN is ignored.

Source files
------------

// File: rtl/sobel_stream_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : sobel_stream_ctrl_pkg                                     |
// | Description : Shared types for the streaming Sobel controller: filter  |
// |               mode and FSM state encodings plus the 3x3 window record. |
// | Revision    : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
package sobel_stream_ctrl_pkg;

    // Pixel width that sizes the window record; the controller's PIXEL_W
    // defaults to this value and must be kept equal to it.
    localparam int unsigned c_PIXEL_W = 8;

    typedef enum logic [1:0] {
        MODE_MAG    = 2'd0,
        MODE_THRESH = 2'd1,
        MODE_GX     = 2'd2,
        MODE_PASS   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // pRC: R = window row (0 = oldest image row), C = window column (0 = leftmost)
    typedef struct packed {
        logic [c_PIXEL_W-1:0] p00;
        logic [c_PIXEL_W-1:0] p01;
        logic [c_PIXEL_W-1:0] p02;
        logic [c_PIXEL_W-1:0] p10;
        logic [c_PIXEL_W-1:0] p11;
        logic [c_PIXEL_W-1:0] p12;
        logic [c_PIXEL_W-1:0] p20;
        logic [c_PIXEL_W-1:0] p21;
        logic [c_PIXEL_W-1:0] p22;
    } window_t;

endpackage
`default_nettype wire

// File: rtl/sobel_line_buffer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : sobel_line_buffer                                         |
// | Description : Column-indexed store of the two previous image rows.     |
// |               Each entry is {row r-2, row r-1}; combinational read,    |
// |               write on enable, storage is never reset.                 |
// | Revision    : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module sobel_line_buffer
    import sobel_stream_ctrl_pkg::*;
#(
    parameter int unsigned PIXEL_W  = c_PIXEL_W,
    parameter int unsigned IMG_W    = 160,
    parameter int unsigned COL_BITS = $clog2(IMG_W)
) (
    input  logic                   clk,
    input  logic                   i_we,
    input  logic [COL_BITS-1:0]    i_addr,
    input  logic [2*PIXEL_W-1:0]   i_wdata,
    output logic [2*PIXEL_W-1:0]   o_rdata
);

    logic [2*PIXEL_W-1:0] r_mem [IMG_W];

    // Store the updated row pair for the column just accepted
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read returns the pre-write contents so the window sees the old rows
    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/sobel_stream_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : sobel_stream_ctrl                                         |
// | Description : Streaming 3x3 Sobel filter controller. Accepts a raster  |
// |               pixel stream, builds one window per accepted pixel and   |
// |               emits filtered interior pixels with backpressure.        |
// | Revision    : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module sobel_stream_ctrl
    import sobel_stream_ctrl_pkg::*;
#(
    parameter int unsigned PIXEL_W  = c_PIXEL_W,
    parameter int unsigned IMG_W    = 160,
    parameter int unsigned IMG_H    = 120,
    parameter int unsigned COL_BITS = $clog2(IMG_W),
    parameter int unsigned ROW_BITS = $clog2(IMG_H)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [1:0]         mode_i,
    input  logic [PIXEL_W-1:0] threshold_i,
    input  logic [PIXEL_W-1:0] in_px_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic [PIXEL_W-1:0] out_px_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               busy_o,
    output logic               frame_done_o
);

    // Gradient width holds +/-4*(2^PIXEL_W-1); magnitude holds the sum of two
    localparam int unsigned c_GW = PIXEL_W + 3;
    localparam int unsigned c_MW = PIXEL_W + 4;

    state_e               r_state;
    logic [COL_BITS-1:0]  r_col;
    logic [ROW_BITS-1:0]  r_row;
    mode_e                r_mode;
    logic [PIXEL_W-1:0]   r_thresh;
    logic                 r_busy;
    logic                 r_frame_done;

    window_t              r_win;
    logic                 r_win_valid;
    logic [PIXEL_W-1:0]   r_out_px;
    logic                 r_out_valid;

    logic                 w_stall;
    logic                 w_in_ready;
    logic                 w_in_xfer;
    logic                 w_col_last;
    logic                 w_row_last;
    logic                 w_win_ok;
    logic [2*PIXEL_W-1:0] w_lb_rd;
    logic [2*PIXEL_W-1:0] w_lb_wr;

    function automatic logic signed [c_GW-1:0] px_ext(input logic [PIXEL_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    // Sobel kernel and output selection for one complete window
    function automatic logic [PIXEL_W-1:0] sobel_kernel(
        input window_t            w,
        input mode_e              mode,
        input logic [PIXEL_W-1:0] thresh
    );
        logic signed [c_GW-1:0] gx;
        logic signed [c_GW-1:0] gy;
        logic [c_GW-1:0]        ax;
        logic [c_GW-1:0]        ay;
        logic [c_MW-1:0]        mag;
        logic [PIXEL_W-1:0]     res;
        gx  = (px_ext(w.p02) + (px_ext(w.p12) <<< 1) + px_ext(w.p22))
            - (px_ext(w.p00) + (px_ext(w.p10) <<< 1) + px_ext(w.p20));
        gy  = (px_ext(w.p20) + (px_ext(w.p21) <<< 1) + px_ext(w.p22))
            - (px_ext(w.p00) + (px_ext(w.p01) <<< 1) + px_ext(w.p02));
        ax  = gx[c_GW-1] ? -gx : gx;
        ay  = gy[c_GW-1] ? -gy : gy;
        mag = {1'b0, ax} + {1'b0, ay};
        case (mode)
            MODE_MAG:    res = (|mag[c_MW-1:PIXEL_W]) ? '1 : mag[PIXEL_W-1:0];
            MODE_THRESH: res = (mag >= {4'b0000, thresh}) ? '1 : '0;
            MODE_GX:     res = (|ax[c_GW-1:PIXEL_W]) ? '1 : ax[PIXEL_W-1:0];
            MODE_PASS:   res = w.p11;
            default:     res = '0;
        endcase
        return res;
    endfunction

    // A held output freezes every stage, so input acceptance follows it directly
    assign w_stall    = r_out_valid & ~out_ready_i;
    assign w_in_ready = (r_state == RUN) & ~w_stall;
    assign w_in_xfer  = in_valid_i & w_in_ready;
    assign w_col_last = (r_col == COL_BITS'(IMG_W - 1));
    assign w_row_last = (r_row == ROW_BITS'(IMG_H - 1));
    assign w_win_ok   = (r_row >= ROW_BITS'(2)) && (r_col >= COL_BITS'(2));

    // Line buffer entry becomes {previous row, current pixel}
    assign w_lb_wr = {w_lb_rd[PIXEL_W-1:0], in_px_i};

    sobel_line_buffer #(
        .PIXEL_W  (PIXEL_W),
        .IMG_W    (IMG_W),
        .COL_BITS (COL_BITS)
    ) u_line_buffer (
        .clk     (clk_i),
        .i_we    (w_in_xfer),
        .i_addr  (r_col),
        .i_wdata (w_lb_wr),
        .o_rdata (w_lb_rd)
    );

    // Frame sequencing: raster counters, configuration latch, busy/done flags
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_mode       <= MODE_MAG;
            r_thresh     <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state  <= RUN;
                        r_busy   <= 1'b1;
                        r_mode   <= mode_e'(mode_i);
                        r_thresh <= threshold_i;
                        r_col    <= '0;
                        r_row    <= '0;
                    end
                end
                RUN: begin
                    if (w_in_xfer) begin
                        if (w_col_last) begin
                            r_col <= '0;
                            if (w_row_last) begin
                                r_state <= DRAIN;
                            end else begin
                                r_row <= r_row + ROW_BITS'(1);
                            end
                        end else begin
                            r_col <= r_col + COL_BITS'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!r_win_valid && !r_out_valid) begin
                        r_state      <= IDLE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Two-stage datapath: window shift register, then filtered output register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_win       <= '0;
            r_win_valid <= 1'b0;
            r_out_px    <= '0;
            r_out_valid <= 1'b0;
        end else if (!w_stall) begin
            r_win_valid <= w_in_xfer & w_win_ok;
            r_out_valid <= r_win_valid;
            if (r_win_valid) begin
                r_out_px <= sobel_kernel(r_win, r_mode, r_thresh);
            end
            if (w_in_xfer) begin
                r_win.p00 <= r_win.p01;
                r_win.p01 <= r_win.p02;
                r_win.p02 <= w_lb_rd[2*PIXEL_W-1:PIXEL_W];
                r_win.p10 <= r_win.p11;
                r_win.p11 <= r_win.p12;
                r_win.p12 <= w_lb_rd[PIXEL_W-1:0];
                r_win.p20 <= r_win.p21;
                r_win.p21 <= r_win.p22;
                r_win.p22 <= in_px_i;
            end
        end
    end

    assign in_ready_o   = w_in_ready;
    assign out_px_o     = r_out_px;
    assign out_valid_o  = r_out_valid;
    assign busy_o       = r_busy;
    assign frame_done_o = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_sobel_stream_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_sobel_stream_ctrl                                      |
// | Description : Self-checking bench for sobel_stream_ctrl on an 8x6      |
// |               frame; expected pixels come from a direct image model.   |
// | Revision    : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module tb_sobel_stream_ctrl;

    localparam int W = 8;
    localparam int H = 6;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic [1:0] mode_i;
    logic [7:0] threshold_i;
    logic [7:0] in_px_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] out_px_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic       busy_o;
    logic       frame_done_o;

    sobel_stream_ctrl #(
        .PIXEL_W (8),
        .IMG_W   (W),
        .IMG_H   (H)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .mode_i       (mode_i),
        .threshold_i  (threshold_i),
        .in_px_i      (in_px_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .out_px_o     (out_px_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    int   errors   = 0;
    int   checks   = 0;
    int   img [H][W];
    int   exp_q[$];
    int   rx_q[$];
    int   done_cnt = 0;
    logic prev_stall = 1'b0;
    int   prev_px    = 0;

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: Sobel applied directly to the stored image, interior pixels in raster order
    function automatic void build_expected(input int mode, input int thr);
        exp_q.delete();
        for (int r = 1; r < H - 1; r++) begin
            for (int c = 1; c < W - 1; c++) begin
                int gx, gy, ax, ay, mag, v;
                gx  = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
                    - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
                gy  = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
                    - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
                ax  = (gx < 0) ? -gx : gx;
                ay  = (gy < 0) ? -gy : gy;
                mag = ax + ay;
                case (mode)
                    0:       v = (mag > 255) ? 255 : mag;
                    1:       v = (mag >= thr) ? 255 : 0;
                    2:       v = (ax > 255) ? 255 : ax;
                    default: v = img[r][c];
                endcase
                exp_q.push_back(v);
            end
        end
    endfunction

    function automatic void make_image(input int kind);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (kind)
                    0:       img[r][c] = 100;
                    1:       img[r][c] = (c < 4) ? 0 : 200;
                    2:       img[r][c] = (r < 3) ? 0 : 200;
                    3:       img[r][c] = 8*r + c;
                    default: img[r][c] = int'($urandom_range(0, 255));
                endcase
            end
        end
    endfunction

    function automatic logic ready_for(input int rdy_mode, input int cyc);
        case (rdy_mode)
            1:       return ($urandom_range(0, 2) != 0);
            2:       return !(cyc >= 30 && cyc < 40);
            default: return 1'b1;
        endcase
    endfunction

    // Output monitor: collects accepted pixels, counts done pulses, checks stall behaviour
    always @(negedge clk_i) begin
        if (reset_i) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", int'(out_valid_o), 1);
                check("stall_hold_px", int'(out_px_o), prev_px);
            end
            if (out_valid_o && !out_ready_i) begin
                check("stall_in_ready", int'(in_ready_o), 0);
            end
            if (out_valid_o && out_ready_i) begin
                rx_q.push_back(int'(out_px_o));
            end
            if (frame_done_o) begin
                done_cnt <= done_cnt + 1;
            end
            prev_stall <= out_valid_o && !out_ready_i;
            prev_px    <= int'(out_px_o);
        end
    end

    // One frame: start, feed pixels, optionally abort with reset, drain and compare
    task automatic run_frame(input int mode, input int thr, input int rdy_mode,
                             input int pulse_cyc, input int abort_after, input string tag);
        int k, cyc, wait_cyc, rx_base, done_base, n;
        build_expected(mode, thr);
        rx_base   = rx_q.size();
        done_base = done_cnt;

        @(posedge clk_i); #1;
        start_i     = 1'b1;
        mode_i      = 2'(mode);
        threshold_i = 8'(thr);
        @(posedge clk_i); #1;
        start_i     = 1'b0;
        mode_i      = 2'($urandom);
        threshold_i = 8'($urandom);
        check({tag, "_busy_run"}, int'(busy_o), 1);

        k   = 0;
        cyc = 0;
        while (k < W*H && cyc < 3000) begin
            in_px_i     = 8'(img[k / W][k % W]);
            in_valid_i  = (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            out_ready_i = ready_for(rdy_mode, cyc);
            start_i     = (cyc == pulse_cyc);
            if (cyc == pulse_cyc) mode_i = 2'd3;
            @(negedge clk_i);
            if (in_valid_i && in_ready_o) k++;
            @(posedge clk_i); #1;
            cyc++;
            if (abort_after > 0 && k == abort_after) break;
        end
        start_i    = 1'b0;
        in_valid_i = 1'b0;

        if (abort_after > 0) begin
            reset_i = 1'b1;
            @(negedge clk_i);
            check({tag, "_rst_out_valid"}, int'(out_valid_o), 0);
            check({tag, "_rst_out_px"}, int'(out_px_o), 0);
            check({tag, "_rst_in_ready"}, int'(in_ready_o), 0);
            check({tag, "_rst_busy"}, int'(busy_o), 0);
            check({tag, "_rst_frame_done"}, int'(frame_done_o), 0);
            @(posedge clk_i); #1;
            reset_i = 1'b0;
            return;
        end

        check({tag, "_fed_pixels"}, k, W*H);
        wait_cyc = 0;
        while (done_cnt == done_base && wait_cyc < 400) begin
            out_ready_i = ready_for(rdy_mode, cyc);
            @(posedge clk_i); #1;
            cyc++;
            wait_cyc++;
        end
        out_ready_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;

        check({tag, "_done_pulses"}, done_cnt - done_base, 1);
        check({tag, "_busy_idle"}, int'(busy_o), 0);
        n = rx_q.size() - rx_base;
        check({tag, "_out_count"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_px%0d", tag, i), (i < n) ? rx_q[rx_base + i] : -1, exp_q[i]);
        end
    endtask

    initial begin
        reset_i     = 1'b1;
        start_i     = 1'b0;
        mode_i      = 2'd0;
        threshold_i = 8'd0;
        in_px_i     = 8'd0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_out_valid", int'(out_valid_o), 0);
        check("reset_out_px", int'(out_px_o), 0);
        check("reset_in_ready", int'(in_ready_o), 0);
        check("reset_busy", int'(busy_o), 0);
        check("reset_frame_done", int'(frame_done_o), 0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;

        make_image(0);
        run_frame(0, 0, 0, -1, 0, "flat_mag");
        make_image(1);
        run_frame(0, 0, 0, -1, 0, "vedge_mag");
        run_frame(2, 0, 0, -1, 0, "vedge_gx");
        make_image(2);
        run_frame(2, 0, 0, -1, 0, "hedge_gx");
        run_frame(0, 0, 0, -1, 0, "hedge_mag");
        make_image(3);
        run_frame(3, 0, 0, -1, 0, "ramp_pass");
        make_image(1);
        run_frame(1, 50, 0, -1, 0, "vedge_thr");
        run_frame(0, 0, 2, -1, 0, "backpressure");
        make_image(0);
        run_frame(0, 0, 0, -1, 20, "abort");
        run_frame(0, 0, 0, 15, 0, "restart");
        for (int t = 0; t < 8; t++) begin
            make_image(4);
            run_frame(t % 4, int'($urandom_range(0, 255)), 1, -1, 0, $sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
